// File: rtl/id_resolve_stage_pkg.sv
// Shared definitions for the decode/resolve stage.
// Holds the opcode and funct constants, the ALU operation encodings, the FSM
// state type, the ID/EX control bundle, the bubble constant and a
// sign-extension helper.
package id_resolve_stage_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation encodings carried into EX
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;

  // jal writes its link value here
  localparam logic [4:0] LINK_REG = 5'd31;

  // Fetch adds PCBranch to PCF (= stalled PC + 4); -4 lands back on the
  // instruction that has to be replayed.
  localparam logic [31:0] REPLAY_OFFSET = 32'hFFFF_FFFC;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_resolve_stage_id_decoder.sv
// Combinational instruction decoder.
// Ports:
//   instr      in   32-bit instruction in ID
//   valid      out  instruction belongs to the supported subset
//   reg_write, mem_read, mem_write, alu_src, alu_op   out  EX controls
//   dest       out  destination register (0 when none)
//   uses_rs/uses_rt  out  instruction reads rs / rt (hazard sources)
//   is_beq, is_bne, is_j, is_jal, is_jr  out  control-flow class
//   imm        out  sign-extended 16-bit immediate
module id_decoder
  import id_resolve_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic        valid,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic [4:0]  dest,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_beq,
  output logic        is_bne,
  output logic        is_j,
  output logic        is_jal,
  output logic        is_jr,
  output logic [31:0] imm
);

  logic [4:0] rt_f;
  logic [4:0] rd_f;
  logic       r_arith;

  assign rt_f = instr[20:16];
  assign rd_f = instr[15:11];

  always_comb begin
    valid     = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    dest      = 5'd0;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    r_arith   = 1'b0;
    imm       = sext16(instr[15:0]);

    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADD: begin r_arith = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin r_arith = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin r_arith = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin r_arith = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin r_arith = 1'b1; alu_op = ALU_SLT; end
          FN_SLL: begin
            // Shift amount travels to EX inside the immediate (bits 10:6).
            valid     = 1'b1;
            reg_write = 1'b1;
            dest      = rd_f;
            uses_rt   = 1'b1;
            alu_op    = ALU_SLL;
          end
          FN_JR: begin
            valid   = 1'b1;
            uses_rs = 1'b1;
            is_jr   = 1'b1;
          end
          default: ;
        endcase
        if (r_arith) begin
          valid     = 1'b1;
          reg_write = 1'b1;
          dest      = rd_f;
          uses_rs   = 1'b1;
          uses_rt   = 1'b1;
        end
      end
      OP_LW: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        alu_src   = 1'b1;
        dest      = rt_f;
        uses_rs   = 1'b1;
      end
      OP_SW: begin
        valid     = 1'b1;
        mem_write = 1'b1;
        alu_src   = 1'b1;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        valid   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_beq  = 1'b1;
      end
      OP_BNE: begin
        valid   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_bne  = 1'b1;
      end
      OP_ADDI: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        dest      = rt_f;
        uses_rs   = 1'b1;
      end
      OP_J: begin
        valid = 1'b1;
        is_j  = 1'b1;
      end
      OP_JAL: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        dest      = LINK_REG;
        is_jal    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_resolve_stage.sv
// Decode/resolve stage: decodes the fetch-registered instruction, resolves
// branches and jumps in ID, drives fetch's redirect inputs, and owns the
// ID/EX pipeline register. Fetch cannot stall, so a data hazard is handled by
// replay: a bubble goes to EX, fetch is squashed and PC is pointed back at the
// stalled instruction.
// Ports:
//   clock, rst_n                  clock, synchronous active-low reset
//   instr_in, pc_f                ID instruction and fetch PCF (= ID PC + 4)
//   rs_data, rt_data              register file read data
//   mem_reg_write, mem_mem_read, mem_dest, mem_alu_result   MEM stage state
//   jump_offset, RegDstJump, PCBranch, PCSrc, clr           fetch redirect
//   ex_*                          ID/EX register outputs
//   replay_cnt                    saturating count of replays since reset
module id_resolve_stage
  import id_resolve_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pc_f,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic [31:0]      mem_alu_result,
  output logic [25:0]      jump_offset,
  output logic             RegDstJump,
  output logic [31:0]      PCBranch,
  output logic             PCSrc,
  output logic             clr,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic [3:0]       ex_alu_op,
  output logic [4:0]       ex_dest,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [31:0]      ex_imm,
  output logic [CNT_W-1:0] replay_cnt
);

  // Decoder outputs
  logic        dec_valid, dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src;
  logic [3:0]  dec_alu_op;
  logic [4:0]  dec_dest;
  logic        dec_uses_rs, dec_uses_rt;
  logic        dec_is_beq, dec_is_bne, dec_is_j, dec_is_jal, dec_is_jr;
  logic [31:0] dec_imm;

  id_decoder u_decoder (
    .instr     (instr_in),
    .valid     (dec_valid),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .alu_src   (dec_alu_src),
    .alu_op    (dec_alu_op),
    .dest      (dec_dest),
    .uses_rs   (dec_uses_rs),
    .uses_rt   (dec_uses_rt),
    .is_beq    (dec_is_beq),
    .is_bne    (dec_is_bne),
    .is_j      (dec_is_j),
    .is_jal    (dec_is_jal),
    .is_jr     (dec_is_jr),
    .imm       (dec_imm)
  );

  // State
  state_t           state_q, state_d;
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  logic [4:0]       ex_dest_q, ex_dest_d;
  logic [4:0]       ex_rs_q, ex_rs_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  logic [31:0]      ex_a_q, ex_a_d;
  logic [31:0]      ex_b_q, ex_b_d;
  logic [31:0]      ex_imm_q, ex_imm_d;
  logic [CNT_W-1:0] replay_cnt_q, replay_cnt_d;

  // Resolve-path signals
  logic [4:0]  rs_idx, rt_idx;
  logic        fwd_ok;
  logic [31:0] rs_val, rt_val;
  logic        br_rs, br_rt;
  logic        haz_ex, haz_mem, haz_lu;
  logic        in_run, hazard, taken;

  assign rs_idx      = instr_in[25:21];
  assign rt_idx      = instr_in[20:16];
  assign jump_offset = instr_in[25:0];

  // Branch operands come from the register file unless a non-load ALU result
  // for the same register is sitting in MEM. Loads in MEM are not usable yet.
  always_comb begin
    fwd_ok = mem_reg_write && !mem_mem_read && (mem_dest != 5'd0);
    rs_val = (fwd_ok && (mem_dest == rs_idx)) ? mem_alu_result : rs_data;
    rt_val = (fwd_ok && (mem_dest == rt_idx)) ? mem_alu_result : rt_data;
  end

  always_comb begin
    br_rs   = dec_is_beq || dec_is_bne || dec_is_jr;
    br_rt   = dec_is_beq || dec_is_bne;
    // Branch source still being computed in EX.
    haz_ex  = ex_ctrl_q.reg_write && (ex_dest_q != 5'd0) &&
              ((br_rs && (rs_idx == ex_dest_q)) || (br_rt && (rt_idx == ex_dest_q)));
    // Branch source still being loaded in MEM.
    haz_mem = mem_mem_read &&
              ((br_rs && (rs_idx == mem_dest)) || (br_rt && (rt_idx == mem_dest)));
    // Classic load-use for any consumer.
    haz_lu  = ex_ctrl_q.mem_read &&
              ((dec_uses_rs && (rs_idx == ex_dest_q)) || (dec_uses_rt && (rt_idx == ex_dest_q)));
    in_run  = rst_n && (state_q == ST_RUN);
    hazard  = in_run && (haz_ex || haz_mem || haz_lu);
    taken   = (dec_is_beq && (rs_val == rt_val)) || (dec_is_bne && (rs_val != rt_val));
  end

  // Redirect outputs; a hazard overrides any jump or branch in the same cycle.
  always_comb begin
    RegDstJump = 1'b0;
    PCSrc      = 1'b0;
    PCBranch   = 32'd0;
    clr        = 1'b0;
    if (hazard) begin
      PCSrc    = 1'b1;
      PCBranch = REPLAY_OFFSET;
      clr      = 1'b1;
    end else if (in_run && (dec_is_j || dec_is_jal)) begin
      RegDstJump = 1'b1;
      clr        = 1'b1;
    end else if (in_run && taken) begin
      PCSrc    = 1'b1;
      PCBranch = {dec_imm[29:0], 2'b00};
      clr      = 1'b1;
    end else if (in_run && dec_is_jr) begin
      // Fetch adds PCF, so hand it the distance to the register target.
      PCSrc    = 1'b1;
      PCBranch = rs_val - pc_f;
      clr      = 1'b1;
    end
  end

  // Next state for the FSM, ID/EX register and replay counter.
  always_comb begin
    state_d      = ST_RUN;
    ex_ctrl_d    = BUBBLE_CTRL;
    ex_dest_d    = 5'd0;
    ex_rs_d      = 5'd0;
    ex_rt_d      = 5'd0;
    ex_a_d       = 32'd0;
    ex_b_d       = 32'd0;
    ex_imm_d     = 32'd0;
    replay_cnt_d = replay_cnt_q;

    if (in_run && clr) begin
      state_d = ST_SQUASH;
    end

    if (in_run && !hazard && dec_valid) begin
      ex_ctrl_d.reg_write = dec_reg_write;
      ex_ctrl_d.mem_read  = dec_mem_read;
      ex_ctrl_d.mem_write = dec_mem_write;
      ex_ctrl_d.alu_src   = dec_alu_src;
      ex_ctrl_d.alu_op    = dec_alu_op;
      ex_dest_d           = dec_dest;
      ex_rs_d             = rs_idx;
      ex_rt_d             = rt_idx;
      // jal computes its link value in EX as pc_f + 0.
      ex_a_d              = dec_is_jal ? pc_f : rs_data;
      ex_b_d              = dec_is_jal ? 32'd0 : rt_data;
      ex_imm_d            = dec_imm;
    end

    if (hazard && (replay_cnt_q != {CNT_W{1'b1}})) begin
      replay_cnt_d = replay_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      ex_ctrl_q    <= BUBBLE_CTRL;
      ex_dest_q    <= 5'd0;
      ex_rs_q      <= 5'd0;
      ex_rt_q      <= 5'd0;
      ex_a_q       <= 32'd0;
      ex_b_q       <= 32'd0;
      ex_imm_q     <= 32'd0;
      replay_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_dest_q    <= ex_dest_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_imm_q     <= ex_imm_d;
      replay_cnt_q <= replay_cnt_d;
    end
  end

  assign ex_reg_write = ex_ctrl_q.reg_write;
  assign ex_mem_read  = ex_ctrl_q.mem_read;
  assign ex_mem_write = ex_ctrl_q.mem_write;
  assign ex_alu_src   = ex_ctrl_q.alu_src;
  assign ex_alu_op    = ex_ctrl_q.alu_op;
  assign ex_dest      = ex_dest_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_a         = ex_a_q;
  assign ex_b         = ex_b_q;
  assign ex_imm       = ex_imm_q;
  assign replay_cnt   = replay_cnt_q;

endmodule

// File: tb/tb_id_resolve_stage.sv
// Scoreboard bench for id_resolve_stage: the stimulus process drives one
// instruction per cycle, works out the expected behaviour from the ISA rules
// and pushes it into a queue; the monitor pops and compares at each negedge.
module tb_id_resolve_stage;
  import id_resolve_stage_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                rst_n;
  logic [31:0]         instr_in, pc_f, rs_data, rt_data, mem_alu_result;
  logic                mem_reg_write, mem_mem_read;
  logic [4:0]          mem_dest;
  logic [25:0]         jump_offset;
  logic                RegDstJump, PCSrc, clr;
  logic [31:0]         PCBranch;
  logic                ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [3:0]          ex_alu_op;
  logic [4:0]          ex_dest, ex_rs, ex_rt;
  logic [31:0]         ex_a, ex_b, ex_imm;
  logic [TB_CNT_W-1:0] replay_cnt;

  id_resolve_stage #(.CNT_W(TB_CNT_W)) dut (
    .clock(clock), .rst_n(rst_n), .instr_in(instr_in), .pc_f(pc_f),
    .rs_data(rs_data), .rt_data(rt_data), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
    .jump_offset(jump_offset), .RegDstJump(RegDstJump), .PCBranch(PCBranch),
    .PCSrc(PCSrc), .clr(clr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_dest(ex_dest), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .replay_cnt(replay_cnt)
  );

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL, K_JR, K_LW, K_SW,
                K_BEQ, K_BNE, K_ADDI, K_J, K_JAL, K_BAD} kind_e;

  typedef struct {
    bit          bubble;
    logic        rw, mr, mw, as;
    logic [3:0]  op;
    logic [4:0]  dest, rs, rt;
    logic [31:0] a, b, imm;
  } idex_t;

  typedef struct {
    int          cyc;
    bit          regs_known;
    idex_t       ex;
    int          cnt;
    logic        pcsrc, rdj, clr;
    logic [31:0] pcb;
    logic [25:0] joff;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  // Reference model state: what the ID/EX register and counter should hold.
  bit    m_known  = 1'b0;
  bit    m_squash = 1'b0;
  idex_t m_ex;
  int    m_cnt    = 0;

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic kind_e classify(logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: case (fn)
               6'h20: return K_ADD;
               6'h22: return K_SUB;
               6'h24: return K_AND;
               6'h25: return K_OR;
               6'h2A: return K_SLT;
               6'h00: return K_SLL;
               6'h08: return K_JR;
               default: return K_BAD;
             endcase
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h08: return K_ADDI;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  function automatic idex_t bubble_ex();
    idex_t x;
    x = '{bubble: 1'b1, rw: 1'b0, mr: 1'b0, mw: 1'b0, as: 1'b0, op: 4'd0,
          dest: 5'd0, rs: 5'd0, rt: 5'd0, a: 32'd0, b: 32'd0, imm: 32'd0};
    return x;
  endfunction

  // One instruction per cycle: drive, predict, push, advance the model.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pcf,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic mrw, input logic mmr, input logic [4:0] mdst,
                       input logic [31:0] malu, input logic rn);
    exp_t              e;
    kind_e             k;
    logic [4:0]        rs, rt;
    logic [4:0]        br_src[$];
    logic [4:0]        use_src[$];
    logic [31:0]       rs_v, rt_v, target;
    logic signed [31:0] simm;
    bit                hz;

    @(posedge clock);
    #1;
    instr_in = ins; pc_f = pcf; rs_data = rsd; rt_data = rtd;
    mem_reg_write = mrw; mem_mem_read = mmr; mem_dest = mdst;
    mem_alu_result = malu; rst_n = rn;
    cyc++;

    k    = classify(ins);
    rs   = ins[25:21];
    rt   = ins[20:16];
    simm = $signed(ins[15:0]);

    case (k)
      K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SW: begin use_src.push_back(rs); use_src.push_back(rt); end
      K_SLL: use_src.push_back(rt);
      K_LW, K_ADDI: use_src.push_back(rs);
      K_JR: begin use_src.push_back(rs); br_src.push_back(rs); end
      K_BEQ, K_BNE: begin
        use_src.push_back(rs); use_src.push_back(rt);
        br_src.push_back(rs);  br_src.push_back(rt);
      end
      default: ;
    endcase

    // Branch operand values: MEM's ALU result if it targets that register.
    rs_v = (mrw && !mmr && mdst != 0 && mdst == rs) ? malu : rsd;
    rt_v = (mrw && !mmr && mdst != 0 && mdst == rt) ? malu : rtd;

    hz = 1'b0;
    foreach (br_src[i]) begin
      if (m_ex.rw && m_ex.dest != 0 && br_src[i] == m_ex.dest) hz = 1'b1;
      if (mmr && br_src[i] == mdst) hz = 1'b1;
    end
    foreach (use_src[i])
      if (m_ex.mr && use_src[i] == m_ex.dest) hz = 1'b1;

    e.cyc = cyc; e.regs_known = m_known; e.ex = m_ex; e.cnt = m_cnt;
    e.pcsrc = 1'b0; e.rdj = 1'b0; e.clr = 1'b0; e.pcb = 32'd0; e.joff = ins[25:0];

    if (!(rn && !m_squash)) hz = 1'b0;
    if (rn && !m_squash) begin
      // Fetch computes PCF + PCBranch, so PCBranch = target - PCF.
      if (hz) begin
        target = pcf - 32'd4;
        e.pcsrc = 1'b1; e.clr = 1'b1; e.pcb = target - pcf;
      end else if (k == K_J || k == K_JAL) begin
        e.rdj = 1'b1; e.clr = 1'b1;
      end else if ((k == K_BEQ && rs_v == rt_v) || (k == K_BNE && rs_v != rt_v)) begin
        target = (pcf - 32'd4) + 32'd4 + 32'(simm * 4);
        e.pcsrc = 1'b1; e.clr = 1'b1; e.pcb = target - pcf;
      end else if (k == K_JR) begin
        target = rs_v;
        e.pcsrc = 1'b1; e.clr = 1'b1; e.pcb = target - pcf;
      end
    end
    sb_q.push_back(e);

    if (!rn) begin
      m_known = 1'b1; m_squash = 1'b0; m_ex = bubble_ex(); m_cnt = 0;
    end else begin
      if (m_squash || hz || k == K_BAD) begin
        m_ex = bubble_ex();
      end else begin
        m_ex.bubble = 1'b0;
        m_ex.rw   = (k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL, K_LW, K_ADDI, K_JAL});
        m_ex.mr   = (k == K_LW);
        m_ex.mw   = (k == K_SW);
        m_ex.as   = (k inside {K_LW, K_SW, K_ADDI});
        case (k)
          K_SUB:   m_ex.op = ALU_SUB;
          K_AND:   m_ex.op = ALU_AND;
          K_OR:    m_ex.op = ALU_OR;
          K_SLT:   m_ex.op = ALU_SLT;
          K_SLL:   m_ex.op = ALU_SLL;
          default: m_ex.op = ALU_ADD;
        endcase
        case (k)
          K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL: m_ex.dest = ins[15:11];
          K_LW, K_ADDI: m_ex.dest = rt;
          K_JAL:        m_ex.dest = 5'd31;
          default:      m_ex.dest = 5'd0;
        endcase
        m_ex.rs  = rs;
        m_ex.rt  = rt;
        m_ex.a   = (k == K_JAL) ? pcf : rsd;
        m_ex.b   = (k == K_JAL) ? 32'd0 : rtd;
        m_ex.imm = 32'(simm);
      end
      if (hz && m_cnt < CNT_MAX) m_cnt++;
      m_squash = !m_squash && e.clr;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, c, act, exp);
    end
  endtask

  // Monitor: compare every cycle that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("clr",        32'(clr),        32'(e.clr),   e.cyc);
        chk("PCSrc",      32'(PCSrc),      32'(e.pcsrc), e.cyc);
        chk("RegDstJump", 32'(RegDstJump), 32'(e.rdj),   e.cyc);
        chk("PCBranch",   PCBranch,        e.pcb,        e.cyc);
        if (e.rdj) chk("jump_offset", 32'(jump_offset), 32'(e.joff), e.cyc);
        if (e.regs_known) begin
          chk("replay_cnt",   32'(replay_cnt),   32'(e.cnt),    e.cyc);
          chk("ex_reg_write", 32'(ex_reg_write), 32'(e.ex.rw),  e.cyc);
          chk("ex_mem_read",  32'(ex_mem_read),  32'(e.ex.mr),  e.cyc);
          chk("ex_mem_write", 32'(ex_mem_write), 32'(e.ex.mw),  e.cyc);
          chk("ex_alu_src",   32'(ex_alu_src),   32'(e.ex.as),  e.cyc);
          chk("ex_alu_op",    32'(ex_alu_op),    32'(e.ex.op),  e.cyc);
          chk("ex_dest",      32'(ex_dest),      32'(e.ex.dest), e.cyc);
          if (!e.ex.bubble) begin
            chk("ex_rs",  32'(ex_rs), 32'(e.ex.rs), e.cyc);
            chk("ex_rt",  32'(ex_rt), 32'(e.ex.rt), e.cyc);
            chk("ex_a",   ex_a,   e.ex.a,   e.cyc);
            chk("ex_b",   ex_b,   e.ex.b,   e.cyc);
            chk("ex_imm", ex_imm, e.ex.imm, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got %0d cycles expected completion", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] ins, rsd, rtd, pcf;
    logic [4:0]  r1, r2, r3;
    logic [15:0] imm;

    m_ex = bubble_ex();
    rst_n = 1'b0; instr_in = '0; pc_f = '0; rs_data = '0; rt_data = '0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_dest = '0; mem_alu_result = '0;

    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b0);
    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b0);
    issue(32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 1'b1);

    // beq r1,r2,+3 taken, then the squash cycle presents it again
    issue(enc_i(6'h04, 5'd1, 5'd2, 16'd3), 32'h104, 5, 5, 0, 0, 0, 0, 1'b1);
    issue(enc_i(6'h04, 5'd1, 5'd2, 16'd3), 32'h104, 5, 5, 0, 0, 0, 0, 1'b1);
    // j 0x40
    issue(enc_j(6'h02, 26'h40), 32'h2000_0008, 0, 0, 0, 0, 0, 0, 1'b1);
    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b1);
    // lw r3 then add r4,r3,r5: replay, squash, add again resolves
    issue(enc_i(6'h23, 5'd1, 5'd3, 16'd0), 32'h204, 9, 0, 0, 0, 0, 0, 1'b1);
    issue(enc_r(6'h20, 5'd3, 5'd5, 5'd4, 5'd0), 32'h208, 1, 2, 0, 0, 0, 0, 1'b1);
    issue(32'h0, 32'h204, 0, 0, 0, 0, 0, 0, 1'b1);
    issue(enc_r(6'h20, 5'd3, 5'd5, 5'd4, 5'd0), 32'h208, 1, 2, 0, 0, 0, 0, 1'b1);
    // bne r6,r0 with r6=7 forwarded from MEM
    issue(enc_i(6'h05, 5'd6, 5'd0, 16'd2), 32'h300, 0, 0, 1, 0, 5'd6, 7, 1'b1);
    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b1);
    // jr r31 and jal
    issue(enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0), 32'h108, 32'h400, 0, 0, 0, 0, 0, 1'b1);
    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b1);
    issue(enc_j(6'h03, 26'h100), 32'h20, 3, 4, 0, 0, 0, 0, 1'b1);
    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b1);
    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b1);
    // reset during a replay cycle
    issue(enc_i(6'h23, 5'd1, 5'd3, 16'd0), 32'h404, 0, 0, 0, 0, 0, 0, 1'b1);
    issue(enc_r(6'h20, 5'd3, 5'd5, 5'd4, 5'd0), 32'h408, 0, 0, 0, 0, 0, 0, 1'b0);
    issue(enc_r(6'h20, 5'd3, 5'd5, 5'd4, 5'd0), 32'h408, 0, 0, 0, 0, 0, 0, 1'b1);
    // drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      issue(enc_i(6'h23, 5'd1, 5'd3, 16'd0), 32'h504, 0, 0, 0, 0, 0, 0, 1'b1);
      issue(enc_r(6'h22, 5'd3, 5'd3, 5'd4, 5'd0), 32'h508, 0, 0, 0, 0, 0, 0, 1'b1);
      issue(32'h0, 32'h504, 0, 0, 0, 0, 0, 0, 1'b1);
    end
    issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      r3  = 5'($urandom_range(0, 7));
      imm = 16'($urandom());
      case ($urandom_range(0, 15))
        0:  ins = enc_r(6'h20, r1, r2, r3, 5'd0);
        1:  ins = enc_r(6'h22, r1, r2, r3, 5'd0);
        2:  ins = enc_r(6'h24, r1, r2, r3, 5'd0);
        3:  ins = enc_r(6'h25, r1, r2, r3, 5'd0);
        4:  ins = enc_r(6'h2A, r1, r2, r3, 5'd0);
        5:  ins = enc_r(6'h00, 5'd0, r2, r3, 5'($urandom_range(0, 31)));
        6:  ins = enc_r(6'h08, r1, 5'd0, 5'd0, 5'd0);
        7:  ins = enc_i(6'h23, r1, r2, imm);
        8:  ins = enc_i(6'h2B, r1, r2, imm);
        9:  ins = enc_i(6'h04, r1, r2, imm);
        10: ins = enc_i(6'h05, r1, r2, imm);
        11: ins = enc_i(6'h08, r1, r2, imm);
        12: ins = enc_j(6'h02, 26'($urandom()));
        13: ins = enc_j(6'h03, 26'($urandom()));
        14: ins = enc_r(6'h3F, r1, r2, r3, 5'd0);
        default: ins = enc_i(6'h3E, r1, r2, imm);
      endcase
      rsd = $urandom_range(0, 3);
      rtd = ($urandom_range(0, 1) == 1) ? rsd : 32'($urandom_range(0, 3));
      pcf = $urandom() & 32'hFFFF_FFFC;
      issue(ins, pcf, rsd, rtd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)), ($urandom_range(0, 99) >= 2));
    end

    repeat (3) @(posedge clock);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_resolve_stage.md
Name: id_resolve_stage

Overview:
- Decode/resolve stage that consumes the fetch stage's registered instruction and its current PCF.
- Drives the fetch stage's redirect inputs: jump_offset, RegDstJump, PCBranch, PCSrc and clr.
- Owns the ID/EX pipeline register.
- Fetch has no stall input, so a data hazard is resolved by *replay*: bubble into EX, squash fetch, and redirect PC back to the stalled instruction.

Parameters:
- CNT_W, 16, width of the saturating replay counter.

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr_in  in  32  instruction from fetch register (instr_out)
- pc_f  in  32  fetch PCF; equals ID instruction PC+4
- rs_data  in  32  register file read port A (write-through on same-cycle write)
- rt_data  in  32  register file read port B
- mem_reg_write  in  1  MEM stage writes a register
- mem_mem_read  in  1  MEM stage is a load
- mem_dest  in  5  MEM stage destination register
- mem_alu_result  in  32  MEM stage ALU result, used for branch forwarding
- jump_offset  out  26  instr_in[25:0]
- RegDstJump  out  1  select absolute jump address
- PCBranch  out  32  offset added to PCF
- PCSrc  out  1  select PCBranch over +4
- clr  out  1  squash the instruction being fetched
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  EX control
- ex_alu_op  out  4  ALU operation
- ex_dest  out  5  destination register (0 means none)
- ex_rs, ex_rt  out  5 each  source register numbers, for EX forwarding
- ex_a, ex_b, ex_imm  out  32 each  operands and sign-extended immediate
- replay_cnt  out  CNT_W  number of replays since reset, saturating

Behaviour:
- Supported ISA subset:
  - R-type funct: add 20h, sub 22h, and 24h, or 25h, slt 2Ah, sll 00h, jr 08h.
  - Opcodes: lw 23h, sw 2Bh, beq 04h, bne 05h, addi 08h, j 02h, jal 03h.
  - Any other opcode or funct decodes as a bubble.
- There is no delay slot. Every redirect asserts clr in the same cycle.
- Redirect outputs are combinational from ID-stage state:
  - j/jal: RegDstJump=1, jump_offset=instr[25:0].
  - beq/bne when taken: PCSrc=1, PCBranch=sext(imm)<<2. Fetch computes PCF+PCBranch, which equals branch_pc+4+imm*4.
  - jr: PCSrc=1, PCBranch=rs_val−pc_f (mod 2^32).
  - When no redirect applies, PCSrc=RegDstJump=clr=0 and PCBranch=0.
- Branch/jr operand value selection:
  - If the operand matches mem_dest, with mem_reg_write=1, mem_mem_read=0 and mem_dest≠0: use mem_alu_result.
  - Otherwise use the register file value.
- Hazard (replay required) if any of the following holds:
  - A branch/jr source matches ex_dest while ex_reg_write=1 (ex_dest≠0).
  - A branch/jr source matches mem_dest while mem_mem_read=1.
  - Any consumer source matches ex_dest while ex_mem_read=1 (load-use).
- Replay response:
  - PCSrc=1, PCBranch=32'hFFFF_FFFC, clr=1, RegDstJump=0.
  - Bubble latched into ID/EX.
  - replay_cnt increments, saturating at all-ones.
  - The instruction re-enters ID 2 cycles later.
  - If a hazard and a taken branch/jump coincide, the hazard wins.
- FSM has two states:
  - RUN.
  - SQUASH: the cycle after any redirect or replay. ID/EX latches a bubble, and redirect/clr outputs are forced to 0. Unconditional return to RUN.
- ID/EX register updates every clock edge.
  - Bubble = all controls 0 and ex_dest=0.
  - jal latches ex_dest=31 with ex_a=pc_f, ex_b=0 and ALU op add; it writes the link value.
  - ex_dest is rd for R-type and rt for lw/addi. sw, branches, j and jr produce no destination.
- Reset (rst_n=0 at an edge): state=RUN, ID/EX=bubble, replay_cnt=0. Redirect outputs remain combinational but are gated to 0 while rst_n=0. A reset mid-replay abandons the replay.

Decomposition:
- Shared package: opcode and funct constants, ALU op encodings, FSM state encoding, the bubble control constant.
- One sub-module: id_decoder, combinational, mapping instr to control fields, dest and immediate.
- Hazard logic, forwarding and the FSM stay in the top module.

Test Plan:
- beq r1,r2,+3 with r1=r2=5, pc_f=0x104 -> PCSrc=1, PCBranch=0x0C, clr=1. Next cycle: SQUASH, ID/EX bubble.
- j 0x0000040, pc_f=0x2000_0008 -> RegDstJump=1, jump_offset=0x0000040, clr=1.
- lw r3 in EX, then add r4,r3,r5 in ID -> PCBranch=0xFFFF_FFFC, clr=1, bubble latched, replay_cnt=1. Add resolves 2 cycles later with no replay.
- add r6 in MEM (mem_alu_result=7), bne r6,r0 in ID -> forwards 7, taken, no replay.
- jr r31 with rs_data=0x400, pc_f=0x108 -> PCBranch=0x2F8. jal at pc_f=0x20 -> ex_dest=31, ex_a=0x20.
- rst_n=0 during a replay cycle -> next cycle ID/EX bubble, replay_cnt=0, PCSrc=0.
